// File: rtl/pkt_rx_buffer.sv
// Receive buffer behind the NoC-to-AXI crossing: per-VC head/body/tail framing check,
// per-VC FWFT FIFOs and packet counters. Define PKT_RX_STORE_FWD_EN for store-and-forward reads.
module pkt_rx_buffer #(
   parameter int FLIT_DATA_WIDTH = 32,
   parameter int N_VIRT_CHN      = 2,
   parameter int BUFFER_DEPTH    = 4,
   localparam int VC_W           = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
) (
   input  logic                       clk_axi,
   input  logic                       arst_axi,
   input  logic                       flit_valid,
   output logic                       flit_ready,
   input  logic [1:0]                 flit_type,
   input  logic [VC_W-1:0]            flit_vc,
   input  logic [FLIT_DATA_WIDTH-1:0] flit_data,
   input  logic [VC_W-1:0]            rd_vc,
   input  logic                       rd_en,
   output logic [FLIT_DATA_WIDTH-1:0] rd_data,
   output logic                       rd_last,
   output logic                       rd_empty,
   output logic [N_VIRT_CHN-1:0]      pkt_avail,
   output logic [N_VIRT_CHN-1:0]      err_framing,
   input  logic [N_VIRT_CHN-1:0]      err_clr,
   output logic [N_VIRT_CHN-1:0]      fsm_state
);

   localparam int AW = $clog2(BUFFER_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(BUFFER_DEPTH + 1);
   localparam int EW = FLIT_DATA_WIDTH + 1;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_IN_PKT = 1'b1
   } vc_state_e;

   // Handshake: a flit transfers on a clock edge where flit_valid && flit_ready;
   // flit_ready depends only on the registered fullness of FIFO[flit_vc].
   vc_state_e             state_q [N_VIRT_CHN];
   vc_state_e             state_d [N_VIRT_CHN];
   logic [PW-1:0]         wr_ptr  [N_VIRT_CHN];
   logic [PW-1:0]         rd_ptr  [N_VIRT_CHN];
   logic [CW-1:0]         pkt_cnt [N_VIRT_CHN];
   logic [EW-1:0]         mem     [N_VIRT_CHN][BUFFER_DEPTH];
   logic [N_VIRT_CHN-1:0] full;
   logic [N_VIRT_CHN-1:0] fifo_empty;
   logic [N_VIRT_CHN-1:0] vc_readable;
   logic [N_VIRT_CHN-1:0] push;
   logic [N_VIRT_CHN-1:0] pop;
   logic [N_VIRT_CHN-1:0] err_set;
   logic                  accept;
   logic                  flit_last;
   logic [EW-1:0]         rd_head;

   always_comb begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
         full[v]       = (wr_ptr[v][AW] != rd_ptr[v][AW]) &&
                         (wr_ptr[v][AW-1:0] == rd_ptr[v][AW-1:0]);
         fifo_empty[v] = (wr_ptr[v] == rd_ptr[v]);
         pkt_avail[v]  = (pkt_cnt[v] != '0);
         fsm_state[v]  = (state_q[v] == S_IN_PKT);
      end
   end

   assign flit_ready = ~full[flit_vc];
   assign accept     = flit_valid & flit_ready;
   assign flit_last  = flit_type[1];

   // Framing FSM per VC: misframed flits are consumed but never stored.
   always_comb begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
         state_d[v] = state_q[v];
         push[v]    = 1'b0;
         err_set[v] = 1'b0;
         if (accept && (flit_vc == VC_W'(v))) begin
            case (state_q[v])
               S_IDLE: begin
                  case (flit_type)
                     2'b00: begin
                        push[v]    = 1'b1;
                        state_d[v] = S_IN_PKT;
                     end
                     2'b11:   push[v]    = 1'b1;
                     default: err_set[v] = 1'b1;
                  endcase
               end
               S_IN_PKT: begin
                  case (flit_type)
                     2'b01: push[v] = 1'b1;
                     2'b10: begin
                        push[v]    = 1'b1;
                        state_d[v] = S_IDLE;
                     end
                     default: err_set[v] = 1'b1;
                  endcase
               end
               default: state_d[v] = S_IDLE;
            endcase
         end
      end
   end

   // A full FIFO with no complete packet stays readable so an oversized packet can drain.
   always_comb begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
`ifdef PKT_RX_STORE_FWD_EN
         vc_readable[v] = !fifo_empty[v] && ((pkt_cnt[v] != '0) || full[v]);
`else
         vc_readable[v] = !fifo_empty[v];
`endif
         pop[v] = rd_en && vc_readable[v] && (rd_vc == VC_W'(v));
      end
   end

   assign rd_head  = mem[rd_vc][rd_ptr[rd_vc][AW-1:0]];
   assign rd_empty = ~vc_readable[rd_vc];
   assign rd_data  = rd_empty ? '0 : rd_head[FLIT_DATA_WIDTH-1:0];
   assign rd_last  = ~rd_empty & rd_head[EW-1];

   always_ff @(posedge clk_axi or posedge arst_axi) begin
      if (arst_axi) begin
         for (int v = 0; v < N_VIRT_CHN; v++) begin
            state_q[v] <= S_IDLE;
            wr_ptr[v]  <= '0;
            rd_ptr[v]  <= '0;
            pkt_cnt[v] <= '0;
         end
         err_framing <= '0;
      end else begin
         for (int v = 0; v < N_VIRT_CHN; v++) begin
            state_q[v] <= state_d[v];
            if (push[v]) wr_ptr[v] <= wr_ptr[v] + PW'(1);
            if (pop[v])  rd_ptr[v] <= rd_ptr[v] + PW'(1);
            // Only the rd_vc FIFO can pop, so rd_head is the entry leaving it.
            case ({push[v] & flit_last, pop[v] & rd_head[EW-1]})
               2'b10:   pkt_cnt[v] <= pkt_cnt[v] + CW'(1);
               2'b01:   pkt_cnt[v] <= pkt_cnt[v] - CW'(1);
               default: pkt_cnt[v] <= pkt_cnt[v];
            endcase
         end
         // A new error outranks a clear arriving in the same cycle.
         err_framing <= (err_framing & ~err_clr) | err_set;
      end
   end

   always_ff @(posedge clk_axi) begin
      for (int v = 0; v < N_VIRT_CHN; v++) begin
         if (push[v]) mem[v][wr_ptr[v][AW-1:0]] <= {flit_last, flit_data};
      end
   end

endmodule

// File: tb/tb_pkt_rx_buffer.sv
// Directed self-checking bench for pkt_rx_buffer (cut-through by default,
// store-and-forward expectations when PKT_RX_STORE_FWD_EN is defined).
module tb_pkt_rx_buffer;

   localparam int DW = 32;
   localparam int NV = 2;
`ifdef PKT_RX_STORE_FWD_EN
   localparam bit SF = 1'b1;
`else
   localparam bit SF = 1'b0;
`endif

   logic          clk_axi = 1'b0;
   logic          arst_axi;
   logic          flit_valid;
   logic          flit_ready;
   logic [1:0]    flit_type;
   logic [0:0]    flit_vc;
   logic [DW-1:0] flit_data;
   logic [0:0]    rd_vc;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_last;
   logic          rd_empty;
   logic [NV-1:0] pkt_avail;
   logic [NV-1:0] err_framing;
   logic [NV-1:0] err_clr;
   logic [NV-1:0] fsm_state;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [1:0] T_HEAD = 2'b00, T_BODY = 2'b01, T_TAIL = 2'b10, T_HT = 2'b11;

   pkt_rx_buffer #(.FLIT_DATA_WIDTH(DW), .N_VIRT_CHN(NV), .BUFFER_DEPTH(4)) dut (
      .clk_axi(clk_axi), .arst_axi(arst_axi), .flit_valid(flit_valid), .flit_ready(flit_ready),
      .flit_type(flit_type), .flit_vc(flit_vc), .flit_data(flit_data), .rd_vc(rd_vc),
      .rd_en(rd_en), .rd_data(rd_data), .rd_last(rd_last), .rd_empty(rd_empty),
      .pkt_avail(pkt_avail), .err_framing(err_framing), .err_clr(err_clr), .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk_axi = ~clk_axi;

   task automatic step();
      @(posedge clk_axi);
      #1;
   endtask

   // driver tasks
   task automatic drive_flit(input logic [0:0] vc, input logic [1:0] ty, input logic [DW-1:0] d);
      flit_valid = 1'b1;
      flit_vc    = vc;
      flit_type  = ty;
      flit_data  = d;
      step();
      flit_valid = 1'b0;
   endtask

   task automatic test_reset();
      arst_axi = 1'b1; flit_valid = 1'b0; flit_type = T_HEAD; flit_vc = '0; flit_data = '0;
      rd_vc = '0; rd_en = 1'b0; err_clr = '0;
      step(); step();
      arst_axi = 1'b0;
      step();
      for (int v = 0; v < NV; v++) begin
         rd_vc = 1'(v); flit_vc = 1'(v); #1;
         n_cmp++; if (flit_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready vc%0d: got %b want 1", v, flit_ready); end
         n_cmp++; if (rd_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty vc%0d: got %b want 1", v, rd_empty); end
         n_cmp++; if (rd_data !== '0 || rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd vc%0d: got %h/%b want 0/0", v, rd_data, rd_last); end
      end
      n_cmp++; if (pkt_avail !== 2'b00 || err_framing !== 2'b00 || fsm_state !== 2'b00) begin
         n_fail++; $display("FAIL reset_flags: got avail=%b err=%b st=%b want 00/00/00", pkt_avail, err_framing, fsm_state); end
      rd_vc = '0; flit_vc = '0;
   endtask

   task automatic test_single_packet();
      logic [DW-1:0] exp_d [3];
      logic          exp_l [3];
      exp_d = '{32'hA0, 32'hA1, 32'hA2};
      exp_l = '{1'b0, 1'b0, 1'b1};
      rd_vc = '0;
      drive_flit(1'b0, T_HEAD, 32'hA0);
      n_cmp++; if (rd_empty !== SF || rd_data !== (SF ? 32'h0 : 32'hA0)) begin
         n_fail++; $display("FAIL head_visible: got empty=%b data=%h want %b/%h", rd_empty, rd_data, SF, SF ? 32'h0 : 32'hA0); end
      drive_flit(1'b0, T_BODY, 32'hA1);
      drive_flit(1'b0, T_TAIL, 32'hA2);
      n_cmp++; if (pkt_avail !== 2'b01) begin n_fail++; $display("FAIL avail_after_tail: got %b want 01", pkt_avail); end
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (rd_empty !== 1'b0 || rd_data !== exp_d[i] || rd_last !== exp_l[i]) begin
            n_fail++; $display("FAIL pkt_read[%0d]: got %b/%h/%b want 0/%h/%b", i, rd_empty, rd_data, rd_last, exp_d[i], exp_l[i]); end
         step();
      end
      rd_en = 1'b0;
      n_cmp++; if (rd_empty !== 1'b1 || rd_data !== '0 || pkt_avail !== 2'b00) begin
         n_fail++; $display("FAIL pkt_drained: got empty=%b data=%h avail=%b want 1/0/00", rd_empty, rd_data, pkt_avail); end
   endtask

   task automatic test_interleave();
      logic [DW-1:0] exp_d [3];
      logic          exp_l [3];
      exp_d = '{32'h20, 32'h21, 32'h22};
      exp_l = '{1'b0, 1'b0, 1'b1};
      rd_vc = '0;
      drive_flit(1'b0, T_HEAD, 32'h10);
      drive_flit(1'b1, T_HEAD, 32'h20);
      drive_flit(1'b0, T_TAIL, 32'h11);
      drive_flit(1'b1, T_BODY, 32'h21);
      rd_en = 1'b1;
      drive_flit(1'b1, T_TAIL, 32'h22);
      n_cmp++; if (rd_data !== 32'h11 || rd_last !== 1'b1 || pkt_avail !== 2'b11) begin
         n_fail++; $display("FAIL write_vc1_pop_vc0: got %h/%b avail=%b want 11/1/11", rd_data, rd_last, pkt_avail); end
      step();
      rd_en = 1'b0;
      n_cmp++; if (rd_empty !== 1'b1 || pkt_avail !== 2'b10) begin
         n_fail++; $display("FAIL vc0_done: got empty=%b avail=%b want 1/10", rd_empty, pkt_avail); end
      rd_vc = 1'b1; #1;
      rd_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (rd_empty !== 1'b0 || rd_data !== exp_d[i] || rd_last !== exp_l[i]) begin
            n_fail++; $display("FAIL vc1_read[%0d]: got %b/%h/%b want 0/%h/%b", i, rd_empty, rd_data, rd_last, exp_d[i], exp_l[i]); end
         step();
      end
      rd_en = 1'b0;
      n_cmp++; if (rd_empty !== 1'b1 || pkt_avail !== 2'b00) begin
         n_fail++; $display("FAIL vc1_done: got empty=%b avail=%b want 1/00", rd_empty, pkt_avail); end
      rd_vc = '0;
   endtask

   task automatic test_full();
      logic [DW-1:0] exp_d [4];
      exp_d = '{32'h31, 32'h32, 32'h33, 32'h35};
      rd_vc = '0;
      drive_flit(1'b0, T_HEAD, 32'h30);
      drive_flit(1'b0, T_BODY, 32'h31);
      drive_flit(1'b0, T_BODY, 32'h32);
      drive_flit(1'b0, T_BODY, 32'h33);
      flit_vc = 1'b0; #1;
      n_cmp++; if (flit_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_vc0: got %b want 0", flit_ready); end
      flit_vc = 1'b1; #1;
      n_cmp++; if (flit_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_vc1: got %b want 1", flit_ready); end
      n_cmp++; if (rd_empty !== 1'b0 || rd_data !== 32'h30 || fsm_state !== 2'b01) begin
         n_fail++; $display("FAIL full_release: got empty=%b data=%h st=%b want 0/30/01", rd_empty, rd_data, fsm_state); end
      // pop while a write to the full VC is offered: write must be refused
      flit_valid = 1'b1; flit_vc = 1'b0; flit_type = T_BODY; flit_data = 32'h34; rd_en = 1'b1; #1;
      n_cmp++; if (flit_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready_before: got %b want 0", flit_ready); end
      step();
      flit_valid = 1'b0; rd_en = 1'b0;
      n_cmp++; if (flit_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_pop: got %b want 1", flit_ready); end
      n_cmp++; if (rd_empty !== SF || rd_data !== (SF ? 32'h0 : 32'h31)) begin
         n_fail++; $display("FAIL after_full_pop: got empty=%b data=%h want %b/%h", rd_empty, rd_data, SF, SF ? 32'h0 : 32'h31); end
      drive_flit(1'b0, T_TAIL, 32'h35);
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (rd_empty !== 1'b0 || rd_data !== exp_d[i] || rd_last !== (i == 3)) begin
            n_fail++; $display("FAIL full_drain[%0d]: got %b/%h/%b want 0/%h/%b", i, rd_empty, rd_data, rd_last, exp_d[i], i == 3); end
         step();
      end
      rd_en = 1'b0;
      n_cmp++; if (rd_empty !== 1'b1 || pkt_avail !== 2'b00 || fsm_state !== 2'b00) begin
         n_fail++; $display("FAIL full_done: got empty=%b avail=%b st=%b want 1/00/00", rd_empty, pkt_avail, fsm_state); end
   endtask

   task automatic test_framing_error();
      rd_vc = 1'b1;
      drive_flit(1'b1, T_BODY, 32'h55);
      n_cmp++; if (rd_empty !== 1'b1 || err_framing !== 2'b10 || pkt_avail !== 2'b00) begin
         n_fail++; $display("FAIL body_in_idle: got empty=%b err=%b avail=%b want 1/10/00", rd_empty, err_framing, pkt_avail); end
      err_clr = 2'b10; step(); err_clr = '0;
      n_cmp++; if (err_framing !== 2'b00) begin n_fail++; $display("FAIL err_clear: got %b want 00", err_framing); end
      err_clr = 2'b10;
      drive_flit(1'b1, T_TAIL, 32'h56);
      err_clr = '0;
      n_cmp++; if (err_framing !== 2'b10) begin n_fail++; $display("FAIL err_beats_clr: got %b want 10", err_framing); end
      err_clr = 2'b10; step(); err_clr = '0;
      rd_vc = 1'b0;
      drive_flit(1'b0, T_HEAD, 32'h60);
      drive_flit(1'b0, T_HT,   32'h61);
      n_cmp++; if (err_framing !== 2'b01 || fsm_state !== 2'b01) begin
         n_fail++; $display("FAIL ht_in_pkt: got err=%b st=%b want 01/01", err_framing, fsm_state); end
      drive_flit(1'b0, T_TAIL, 32'h62);
      rd_en = 1'b1;
      n_cmp++; if (rd_data !== 32'h60 || rd_last !== 1'b0) begin n_fail++; $display("FAIL err_pkt_rd0: got %h/%b want 60/0", rd_data, rd_last); end
      step();
      n_cmp++; if (rd_data !== 32'h62 || rd_last !== 1'b1) begin n_fail++; $display("FAIL err_pkt_rd1: got %h/%b want 62/1", rd_data, rd_last); end
      step();
      rd_en = 1'b0;
      n_cmp++; if (rd_empty !== 1'b1 || pkt_avail !== 2'b00) begin n_fail++; $display("FAIL err_pkt_done: got %b/%b want 1/00", rd_empty, pkt_avail); end
      err_clr = 2'b01; step(); err_clr = '0;
      n_cmp++; if (err_framing !== 2'b00) begin n_fail++; $display("FAIL err_clr_vc0: got %b want 00", err_framing); end
   endtask

   task automatic test_head_tail_and_reset();
      rd_vc = '0; rd_en = 1'b1;
      drive_flit(1'b0, T_HT, 32'h7);
      n_cmp++; if (rd_empty !== 1'b0 || rd_data !== 32'h7 || rd_last !== 1'b1 || pkt_avail !== 2'b01) begin
         n_fail++; $display("FAIL ht_read: got %b/%h/%b avail=%b want 0/7/1/01", rd_empty, rd_data, rd_last, pkt_avail); end
      step();
      n_cmp++; if (rd_empty !== 1'b1 || pkt_avail !== 2'b00) begin n_fail++; $display("FAIL ht_popped: got %b/%b want 1/00", rd_empty, pkt_avail); end
      step();
      rd_en = 1'b0;
      n_cmp++; if (rd_empty !== 1'b1 || pkt_avail !== 2'b00 || flit_ready !== 1'b1) begin
         n_fail++; $display("FAIL rd_empty_ignored: got %b/%b/%b want 1/00/1", rd_empty, pkt_avail, flit_ready); end
      drive_flit(1'b0, T_HT,   32'h90);
      drive_flit(1'b0, T_BODY, 32'h91);
      drive_flit(1'b1, T_HEAD, 32'h80);
      n_cmp++; if (pkt_avail !== 2'b01 || err_framing !== 2'b01 || fsm_state !== 2'b10) begin
         n_fail++; $display("FAIL pre_reset: got avail=%b err=%b st=%b want 01/01/10", pkt_avail, err_framing, fsm_state); end
      #2 arst_axi = 1'b1;
      #1;
      for (int v = 0; v < NV; v++) begin
         rd_vc = 1'(v); flit_vc = 1'(v); #1;
         n_cmp++; if (rd_empty !== 1'b1 || rd_data !== '0 || rd_last !== 1'b0 || flit_ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset vc%0d: got %b/%h/%b/%b want 1/0/0/1", v, rd_empty, rd_data, rd_last, flit_ready); end
      end
      n_cmp++; if (pkt_avail !== 2'b00 || err_framing !== 2'b00 || fsm_state !== 2'b00) begin
         n_fail++; $display("FAIL async_reset_flags: got %b/%b/%b want 00/00/00", pkt_avail, err_framing, fsm_state); end
      @(negedge clk_axi) arst_axi = 1'b0;
      step();
      rd_vc = 1'b1;
      drive_flit(1'b1, T_BODY, 32'h82);
      n_cmp++; if (err_framing !== 2'b10 || rd_empty !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_idle: got err=%b empty=%b want 10/1", err_framing, rd_empty); end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_interleave();
      test_full();
      test_framing_error();
      test_head_tail_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
